// File: rtl/host_mailbox.sv
// Host/CPU mailbox: a shared byte RAM plus two message registers, bridging an
// asynchronous SRAM-style host port to a Wishbone slave port.
module host_mailbox #(
    parameter int ram_adr_width = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic [12:0] addr,
    inout  wire  [7:0]  sram_data,
    input  logic        nwe,
    input  logic        noe,
    input  logic        ncs
);
    localparam int word_aw = ram_adr_width - 2;
    localparam int depth   = 1 << word_aw;

    logic               ncs_m, ncs_s;
    logic               nwe_m, nwe_s, nwe_d;
    logic               noe_m, noe_s, noe_d;
    logic [12:0]        addr_m, addr_s, host_addr_q;
    logic [7:0]         data_m, data_s;
    logic               host_commit, host_rd_end, host_in_ram;
    logic               host_rd_slot, host_slot_q;
    logic [word_aw-1:0] host_idx, wb_idx;
    logic [31:0]        mem [depth];
    logic [31:0]        ram_rdata, host_word, reg_rdata, status_word;
    logic               wb_req, wb_ram_go, wb_reg_go, wb_ram_q;
    logic               h2c_flag, c2h_flag;
    logic [7:0]         h2c_msg, c2h_msg, rd_reg, host_rd_byte;
    logic               unused_adr_bits;

    // Host pins are asynchronous: two flops each, plus a delayed copy of the
    // strobes for edge detection. Strobes reset to idle so a genuine 1->0->1
    // is needed after reset before any host edge is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ncs_m  <= 1'b1;
            ncs_s  <= 1'b1;
            nwe_m  <= 1'b1;
            nwe_s  <= 1'b1;
            nwe_d  <= 1'b1;
            noe_m  <= 1'b1;
            noe_s  <= 1'b1;
            noe_d  <= 1'b1;
            addr_m <= 13'd0;
            addr_s <= 13'd0;
            data_m <= 8'd0;
            data_s <= 8'd0;
        end else begin
            ncs_m  <= ncs;
            ncs_s  <= ncs_m;
            nwe_m  <= nwe;
            nwe_s  <= nwe_m;
            nwe_d  <= nwe_s;
            noe_m  <= noe;
            noe_s  <= noe_m;
            noe_d  <= noe_s;
            addr_m <= addr;
            addr_s <= addr_m;
            data_m <= sram_data;
            data_s <= data_m;
        end
    end

    assign host_commit  = nwe_s & ~nwe_d & ~ncs_s;
    assign host_rd_end  = noe_s & ~noe_d & ~ncs_s;
    assign host_in_ram  = (addr_s >> ram_adr_width) == 13'd0;
    assign host_idx     = addr_s[ram_adr_width-1:2];
    assign wb_idx       = wb_adr_i[ram_adr_width-1:2];

    // The single RAM port goes to a host commit first, then Wishbone, and any
    // leftover cycle refreshes the host read word.
    assign wb_req       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_ram_go    = wb_req & ~wb_adr_i[12] & ~host_commit;
    assign wb_reg_go    = wb_req & wb_adr_i[12];
    assign host_rd_slot = ~ncs_s & ~noe_s & ~host_commit & ~wb_ram_go;

    assign status_word  = {c2h_msg, 8'h00, h2c_msg, 6'b000000, c2h_flag, h2c_flag};
    assign wb_dat_o     = !wb_ack_o ? 32'd0 : (wb_ram_q ? ram_rdata : reg_rdata);
    assign intr         = h2c_flag;
    assign sram_data    = (!ncs && !noe && nwe) ? rd_reg : 8'bzzzzzzzz;

    assign unused_adr_bits = ^{wb_adr_i[31:13], wb_adr_i[11:ram_adr_width], wb_adr_i[1:0]};

    // Byte 0 of each word lives in bits [31:24], matching LM32 byte order.
    always_ff @(posedge clk) begin
        if (host_commit && host_in_ram) begin
            mem[host_idx][{~addr_s[1:0], 3'b000} +: 8] <= data_s;
        end else if (wb_ram_go) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_we_i && wb_sel_i[i]) begin
                    mem[wb_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
            ram_rdata <= mem[wb_idx];
        end else if (host_rd_slot) begin
            host_word <= mem[host_idx];
        end
    end

    always_comb begin
        host_rd_byte = 8'h00;
        if ((host_addr_q >> ram_adr_width) == 13'd0) begin
            host_rd_byte = host_word[{~host_addr_q[1:0], 3'b000} +: 8];
        end else if (host_addr_q == 13'h1FFF) begin
            host_rd_byte = h2c_msg;
        end else if (host_addr_q == 13'h1FFE) begin
            host_rd_byte = c2h_msg;
        end else if (host_addr_q == 13'h1FFD) begin
            host_rd_byte = {6'b000000, c2h_flag, h2c_flag};
        end
    end

    // Flag clears are written before sets so a coincident set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o    <= 1'b0;
            wb_ram_q    <= 1'b0;
            reg_rdata   <= 32'd0;
            h2c_flag    <= 1'b0;
            c2h_flag    <= 1'b0;
            h2c_msg     <= 8'd0;
            c2h_msg     <= 8'd0;
            host_slot_q <= 1'b0;
            host_addr_q <= 13'd0;
            rd_reg      <= 8'd0;
        end else begin
            wb_ack_o <= wb_ram_go | wb_reg_go;
            if (wb_ram_go || wb_reg_go) begin
                wb_ram_q  <= wb_ram_go;
                reg_rdata <= status_word;
            end
            if (wb_reg_go && wb_we_i && !wb_adr_i[2] && wb_sel_i[0] && wb_dat_i[0]) begin
                h2c_flag <= 1'b0;
            end
            if (host_rd_end && addr_s == 13'h1FFE) begin
                c2h_flag <= 1'b0;
            end
            if (host_commit && addr_s == 13'h1FFF) begin
                h2c_msg  <= data_s;
                h2c_flag <= 1'b1;
            end
            if (wb_reg_go && wb_we_i && wb_adr_i[2] && wb_sel_i[3]) begin
                c2h_msg  <= wb_dat_i[31:24];
                c2h_flag <= 1'b1;
            end
            host_slot_q <= host_rd_slot;
            host_addr_q <= addr_s;
            if (host_slot_q) begin
                rd_reg <= host_rd_byte;
            end
        end
    end

endmodule
